lz77_stream_decoder: RTL and testbench

- Parametrised LZ77 decoder. It is the next generation of the fixed LZE decode path: the window depth, match length and character width are generalised.
- It consumes (offset, match_len, char_nxt) triples over a valid/ready handshake and emits the decoded character stream. The output has valid/ready backpressure.
- It sits downstream of the LZ77 encoder or a code FIFO and feeds a byte sink.
- It decodes a sequence of strings. Each string ends at END_CHAR, and the dictionary clears between strings.

---
 rtl/lzd_pkg.sv | 24 ++
 rtl/lzd_window.sv | 40 ++++
 rtl/lz77_stream_decoder.sv | 192 +++++++++++++++++++
 tb/tb_lz77_stream_decoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lzd_pkg.sv
// Shared types and constants for the LZ77 stream decoder.
// Holds the FSM state encoding, the default end-of-string literal and
// width helpers used to derive the offset and match-length field widths.
package lzd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        LIT  = 2'd2
    } lzd_state_e;

    localparam logic [7:0] LZD_END_CHAR = 8'h45;

    // Offset field width: enough bits to address every window slot.
    function automatic int lzd_off_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Match-length field width: must represent 0..max_len inclusive.
    function automatic int lzd_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/lzd_window.sv
// Search window: DEPTH x W shift register, slot 0 = most recent character.
// Ports: clk_i/rst_ni (async active-low), shift_en_i pushes shift_dat_i into
// slot 0, clear_i zeroes all slots (wins over shift), rd_idx_i/rd_dat_o is a
// combinational read; indices at or beyond DEPTH read as 0.
module lzd_window #(
    parameter int DEPTH = 9,
    parameter int W     = 8,
    parameter int IDX_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             shift_en_i,
    input  logic             clear_i,
    input  logic [W-1:0]     shift_dat_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [W-1:0]     rd_dat_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (shift_en_i) begin
            mem_q[0] <= shift_dat_i;
            for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
        end
    end

    // Compare-based mux so out-of-range indices fall through to 0.
    always_comb begin
        rd_dat_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx_i == IDX_W'(i)) rd_dat_o = mem_q[i];
        end
    end

endmodule

// File: rtl/lz77_stream_decoder.sv
// LZ77 decoder: turns (offset, length, literal) triples into a character
// stream; one output beat per cycle, first beat 1 cycle after accept.
// Backpressure: out_ready low freezes output, window and counters; a new
// triple is taken on the edge of the final literal beat for len+1 cycles/triple.
//
// Ports: clk, reset (async active-low); code_valid/code_ready with
// code_pos/code_len/code_char in; out_valid/out_ready with out_char/out_last
// out; busy = not idle; err = sticky offset error.
// Optional macro LZD_CHECK_EN enables the offset range check driving err;
// without it err is tied to 0.
module lz77_stream_decoder
    import lzd_pkg::*;
#(
    parameter int                CHAR_W       = 8,
    parameter int                SEARCH_DEPTH = 9,
    parameter int                MAX_LEN      = 8,
    // Derived widths; leave at their defaults.
    parameter int                OFF_W        = lzd_off_w(SEARCH_DEPTH),
    parameter int                LEN_W        = lzd_len_w(MAX_LEN),
    parameter logic [CHAR_W-1:0] END_CHAR     = CHAR_W'(LZD_END_CHAR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic [OFF_W-1:0]  code_pos,
    input  logic [LEN_W-1:0]  code_len,
    input  logic [CHAR_W-1:0] code_char,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CHAR_W-1:0] out_char,
    output logic              out_last,
    output logic              busy,
    output logic              err
);

    localparam int                FILL_W   = $clog2(SEARCH_DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEARCH_DEPTH);
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);

    lzd_state_e        state_q;
    logic [OFF_W-1:0]  pos_q;
    logic [LEN_W-1:0]  rem_q;
    logic [CHAR_W-1:0] char_q;
    logic              bad_q;
    logic              out_valid_q;
    logic [CHAR_W-1:0] out_char_q;
    logic              out_last_q;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;

    logic              out_hs;
    logic              accept;
    logic              win_clear;
    logic              bad_acc;
    logic [LEN_W-1:0]  len_eff;
    logic [OFF_W-1:0]  rd_pos;
    logic [OFF_W-1:0]  win_idx;
    logic [CHAR_W-1:0] win_dat;
    logic [CHAR_W-1:0] rd_next;

    assign out_hs     = out_valid_q & out_ready;
    assign win_clear  = out_hs & out_last_q;
    assign code_ready = (state_q == IDLE) || ((state_q == LIT) && out_ready);
    assign accept     = code_valid & code_ready;
    assign len_eff    = (code_len > LEN_MAX) ? LEN_MAX : code_len;

    // The next copy beat must see the window as it will be after this edge's
    // shift (or clear). Slot p after a shift is old slot p-1, and slot 0 is
    // the character leaving the output register right now.
    assign rd_pos  = accept ? code_pos : pos_q;
    assign win_idx = (out_hs && (rd_pos != '0)) ? rd_pos - OFF_W'(1) : rd_pos;

    always_comb begin
        fill_d = fill_q;
        if (win_clear) begin
            fill_d = '0;
        end else if (out_hs && (fill_q != FILL_MAX)) begin
            fill_d = fill_q + FILL_W'(1);
        end
    end

    // Slots at or beyond the fill count only ever hold zero, so gating on the
    // post-edge fill count also covers the clear and out-of-range offsets.
    always_comb begin
        rd_next = win_dat;
        if (win_clear || (32'(rd_pos) >= SEARCH_DEPTH) || (32'(rd_pos) >= 32'(fill_d))) begin
            rd_next = '0;
        end else if (out_hs && (rd_pos == '0)) begin
            rd_next = out_char_q;
        end
    end

`ifdef LZD_CHECK_EN
    assign bad_acc = (len_eff != '0) &&
                     ((32'(code_pos) >= 32'(fill_d)) || (32'(code_pos) >= SEARCH_DEPTH));
`else
    assign bad_acc = 1'b0;
`endif

    lzd_window #(
        .DEPTH (SEARCH_DEPTH),
        .W     (CHAR_W),
        .IDX_W (OFF_W)
    ) u_window (
        .clk_i       (clk),
        .rst_ni      (reset),
        .shift_en_i  (out_hs),
        .clear_i     (win_clear),
        .shift_dat_i (out_char_q),
        .rd_idx_i    (win_idx),
        .rd_dat_o    (win_dat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pos_q       <= '0;
            rem_q       <= '0;
            char_q      <= '0;
            bad_q       <= 1'b0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_char_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            fill_q <= fill_d;
            if (accept) begin
                // Accept can coincide with the final LIT beat handshake.
                pos_q       <= code_pos;
                char_q      <= code_char;
                bad_q       <= bad_acc;
                out_valid_q <= 1'b1;
                if (len_eff != '0) begin
                    state_q    <= COPY;
                    rem_q      <= len_eff;
                    out_char_q <= bad_acc ? '0 : rd_next;
                    out_last_q <= 1'b0;
                end else begin
                    state_q    <= LIT;
                    rem_q      <= '0;
                    out_char_q <= code_char;
                    out_last_q <= (code_char == END_CHAR);
                end
            end else if (out_hs) begin
                case (state_q)
                    COPY: begin
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_q    <= LIT;
                            out_char_q <= char_q;
                            out_last_q <= (char_q == END_CHAR);
                        end else begin
                            out_char_q <= bad_q ? '0 : rd_next;
                        end
                    end
                    default: begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef LZD_CHECK_EN
    logic err_q;

    // A fresh error on an accept wins over the clear from the END beat that
    // closes the previous string on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (accept && bad_acc) begin
            err_q <= 1'b1;
        end else if (win_clear) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lz77_stream_decoder.sv
// Directed bench for lz77_stream_decoder: table of triples with expected
// streams plus hand sequences for backpressure, back-to-back, offset error
// and reset mid-copy.
module tb_lz77_stream_decoder;

    localparam logic [7:0] E = 8'h45;
`ifdef LZD_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       code_valid = 1'b0;
    logic       code_ready;
    logic [3:0] code_pos = 4'd0;
    logic [3:0] code_len = 4'd0;
    logic [7:0] code_char = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_char;
    logic       out_last;
    logic       busy;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_cnt = 0;

    lz77_stream_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_pos   (code_pos),
        .code_len   (code_len),
        .code_char  (code_char),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_char   (out_char),
        .out_last   (out_last),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        string       name;
        logic [3:0]  pos;
        logic [3:0]  len;
        logic [7:0]  ch;
        int          n;
        logic [79:0] exp;   // expected beats, last beat in the low byte
        logic        err;   // expected err afterwards when the check is built in
    } vec_t;

    vec_t vt [10];

    function automatic vec_t mk(input string nm, input logic [3:0] p, input logic [3:0] l,
                                input logic [7:0] c, input int n, input logic [79:0] e,
                                input logic er);
        vec_t v;
        v.name = nm; v.pos = p; v.len = l; v.ch = c; v.n = n; v.exp = e; v.err = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Gathers n beats starting at the current negedge; optionally holds
    // out_ready low for stall_cyc cycles when beat stall_beat is presented.
    task automatic collect(input int n, input int stall_beat, input int stall_cyc,
                           output logic [79:0] got, output logic [9:0] lasts);
        int b = 0;
        int st = 0;
        int cyc = 0;
        logic [8:0] hold = 9'h0;
        got = '0;
        lasts = '0;
        while (b < n && cyc < 100) begin
            if (out_valid === 1'b1) begin
                if (b == stall_beat && st < stall_cyc) begin
                    if (st == 0) hold = {out_last, out_char};
                    else check("bp_hold", 32'({out_last, out_char}), 32'(hold));
                    out_ready = 1'b0;
                    st++;
                end else begin
                    if (b == stall_beat && stall_cyc > 0)
                        check("bp_release", 32'({out_last, out_char}), 32'(hold));
                    out_ready = 1'b1;
                    got   = {got[71:0], out_char};
                    lasts = {lasts[8:0], out_last};
                    b++;
                end
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
        if (b < n) check("collect_timeout", 32'(b), 32'(n));
    endtask

    task automatic run_triple(input string name, input logic [3:0] pos, input logic [3:0] len,
                              input logic [7:0] ch, input int n, input logic [79:0] exp,
                              input int stall_beat, input int stall_cyc);
        logic [79:0] got;
        logic [9:0]  lasts;
        @(negedge clk);
        code_pos = pos; code_len = len; code_char = ch; code_valid = 1'b1; out_ready = 1'b1;
        #1 check({name, "_rdy"}, 32'(code_ready), 32'd1);
        @(negedge clk);
        code_valid = 1'b0;
        check({name, "_lat"}, 32'(out_valid), 32'd1);
        collect(n, stall_beat, stall_cyc, got, lasts);
        for (int b = 0; b < n; b++)
            check($sformatf("%s_beat%0d", name, b), 32'(got[8*(n-1-b) +: 8]),
                  32'(exp[8*(n-1-b) +: 8]));
        check({name, "_last"}, 32'(lasts), (ch == E) ? 32'd1 : 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = mk("lit_a", 4'd0,  4'd0,  "a", 1, 80'("a"),         1'b0);
        vt[1] = mk("lit_b", 4'd0,  4'd0,  "b", 1, 80'("b"),         1'b0);
        vt[2] = mk("ovl",   4'd1,  4'd5,  "c", 6, 80'("ababac"),    1'b0);
        vt[3] = mk("end1",  4'd0,  4'd0,  E,   1, 80'(E),           1'b0);
        vt[4] = mk("lit_p", 4'd0,  4'd0,  "p", 1, 80'("p"),         1'b0);
        vt[5] = mk("cp1",   4'd0,  4'd1,  "r", 2, 80'("pr"),        1'b0);
        vt[6] = mk("cp6",   4'd2,  4'd6,  "s", 7, 80'("pprpprs"),   1'b0);
        vt[7] = mk("deep",  4'd8,  4'd1,  "t", 2, 80'("pt"),        1'b0);
        vt[8] = mk("oob",   4'd12, 4'd2,  "u", 3, 80'({16'h0, "u"}), 1'b1);
        vt[9] = mk("clip",  4'd0,  4'd12, E,   9, 80'("uuuuuuuuE"), 1'b0);

        // Reset state
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_char",  32'(out_char),  32'd0);
        check("rst_last",  32'(out_last),  32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_err",   32'(err),       32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_triple(vt[i].name, vt[i].pos, vt[i].len, vt[i].ch, vt[i].n, vt[i].exp, -1, 0);
            check({vt[i].name, "_err"}, 32'(err), 32'(CHK & vt[i].err));
        end

        // Backpressure on the third copy beat
        run_triple("bp_a", 4'd0, 4'd0, "a", 1, 80'("a"), -1, 0);
        run_triple("bp_b", 4'd0, 4'd0, "b", 1, 80'("b"), -1, 0);
        run_triple("bp_copy", 4'd1, 4'd5, "c", 6, 80'("ababac"), 2, 3);
        run_triple("bp_end", 4'd0, 4'd0, E, 1, 80'(E), -1, 0);

        // Back-to-back triples with code_valid held high
        begin : b2b
            logic [79:0] got;
            logic [9:0]  lasts;
            int          acc_cyc [3];
            @(negedge clk);
            fork
                begin
                    logic acc;
                    for (int k = 0; k < 3; k++) begin
                        code_pos   = 4'd0;
                        code_len   = (k == 1) ? 4'd2 : 4'd0;
                        code_char  = (k == 0) ? "x" : (k == 1) ? "y" : E;
                        code_valid = 1'b1;
                        acc = 1'b0;
                        for (int w = 0; w < 20 && !acc; w++) begin
                            #1;
                            if (code_ready) begin
                                acc = 1'b1;
                                acc_cyc[k] = cyc_cnt;
                            end
                            @(negedge clk);
                        end
                        if (!acc) check("b2b_accept_timeout", 32'(k), 32'd99);
                    end
                    code_valid = 1'b0;
                end
                collect(5, -1, 0, got, lasts);
            join
            check("b2b_stream", got[39:0], 32'("xxxyE"));
            check("b2b_stream_hi", 32'(got[79:40]), 32'd0);
            check("b2b_last", 32'(lasts), 32'd1);
            check("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
            check("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
            check("b2b_busy", 32'(busy), 32'd0);
        end

        // Offset beyond fill count
        run_triple("ck_g", 4'd0, 4'd0, "g", 1, 80'("g"), -1, 0);
        run_triple("ck_h", 4'd0, 4'd0, "h", 1, 80'("h"), -1, 0);
        run_triple("ck_z", 4'd3, 4'd1, "z", 2, 80'({8'h00, "z"}), -1, 0);
        check("ck_err_set", 32'(err), 32'(CHK));
        run_triple("ck_end", 4'd0, 4'd0, E, 1, 80'(E), -1, 0);
        check("ck_err_clr", 32'(err), 32'd0);

        // Reset during the third copy beat
        run_triple("rs_a", 4'd0, 4'd0, "a", 1, 80'("a"), -1, 0);
        run_triple("rs_b", 4'd0, 4'd0, "b", 1, 80'("b"), -1, 0);
        @(negedge clk);
        code_pos = 4'd1; code_len = 4'd5; code_char = "c"; code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        check("rs_beat0", 32'(out_char), 32'("a"));
        @(negedge clk);
        check("rs_beat1", 32'(out_char), 32'("b"));
        @(negedge clk);
        check("rs_beat2", 32'(out_char), 32'("a"));
        check("rs_busy_pre", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("rs_valid", 32'(out_valid), 32'd0);
        check("rs_char",  32'(out_char),  32'd0);
        check("rs_last",  32'(out_last),  32'd0);
        check("rs_busy",  32'(busy),      32'd0);
        check("rs_err",   32'(err),       32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_triple("rs_q", 4'd0, 4'd0, "q", 1, 80'("q"), -1, 0);
        run_triple("rs_dict", 4'd1, 4'd1, "w", 2, 80'({8'h00, "w"}), -1, 0);
        check("rs_dict_err", 32'(err), 32'(CHK));
        run_triple("rs_end", 4'd0, 4'd0, E, 1, 80'(E), -1, 0);
        check("rs_end_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
